hack_alu_pipe: RTL and testbench

//   Parametrised, two-stage pipelined successor of the Hack ALU (zx/nx/zy/ny/f/no control set).
//   - Generalised to WIDTH bits.
//   - Adds a valid/ready handshake on both sides, with full backpressure.
//   - Sits between the CPU decode stage and the writeback/D-register path.
//   - Result returns with its zr/ng status flags.

---
 rtl/hack_alu_pipe.sv | 150 +++++++++++++++
 tb/tb_hack_alu_pipe.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/hack_alu_pipe.sv
// Two-stage pipelined Hack ALU with valid/ready handshake on both sides.
// Define ALU_OVF_EN to add the registered signed-overflow flag on ov_o; otherwise ov_o is tied low.
module hack_alu_pipe #(
  parameter int WIDTH = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [WIDTH-1:0] x_i,
  input  logic [WIDTH-1:0] y_i,
  input  logic             zx_i,
  input  logic             nx_i,
  input  logic             zy_i,
  input  logic             ny_i,
  input  logic             f_i,
  input  logic             no_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [WIDTH-1:0] out_o,
  output logic             zr_o,
  output logic             ng_o,
  output logic             ov_o
);

  localparam int MSB = WIDTH - 1;

  logic             s1_valid_q, s1_valid_d;
  logic [WIDTH-1:0] s1_x_q, s1_x_d;
  logic [WIDTH-1:0] s1_y_q, s1_y_d;
  logic             s1_f_q, s1_f_d;
  logic             s1_no_q, s1_no_d;

  logic             s2_valid_q, s2_valid_d;
  logic [WIDTH-1:0] s2_out_q, s2_out_d;
  logic             s2_zr_q, s2_zr_d;
  logic             s2_ng_q, s2_ng_d;

  logic             s2_free;
  logic             s1_adv;
  logic             in_xfer;

  logic [WIDTH-1:0] x_zeroed, y_zeroed;
  logic [WIDTH-1:0] xp, yp;
  logic [WIDTH-1:0] sum, r, res;

  always_comb begin
    s2_free = !s2_valid_q || ready_i;
    s1_adv  = s1_valid_q && s2_free;
    ready_o = !s1_valid_q || s2_free;
    in_xfer = valid_i && ready_o;
  end

  // S1: operand preprocessing, loaded only on an accepted input beat
  always_comb begin
    x_zeroed = zx_i ? '0 : x_i;
    y_zeroed = zy_i ? '0 : y_i;
    xp       = nx_i ? ~x_zeroed : x_zeroed;
    yp       = ny_i ? ~y_zeroed : y_zeroed;

    s1_x_d  = s1_x_q;
    s1_y_d  = s1_y_q;
    s1_f_d  = s1_f_q;
    s1_no_d = s1_no_q;
    if (in_xfer) begin
      s1_x_d  = xp;
      s1_y_d  = yp;
      s1_f_d  = f_i;
      s1_no_d = no_i;
    end

    s1_valid_d = s1_valid_q;
    if (in_xfer) begin
      s1_valid_d = 1'b1;
    end else if (s1_adv) begin
      s1_valid_d = 1'b0;
    end
  end

  // S2: compute and flag generation; the stage holds its contents while stalled
  always_comb begin
    sum = s1_x_q + s1_y_q;
    r   = s1_f_q ? sum : (s1_x_q & s1_y_q);
    res = s1_no_q ? ~r : r;

    s2_out_d = s2_out_q;
    s2_zr_d  = s2_zr_q;
    s2_ng_d  = s2_ng_q;
    if (s1_adv) begin
      s2_out_d = res;
      s2_zr_d  = (res == '0);
      s2_ng_d  = res[MSB];
    end

    s2_valid_d = s1_adv || (s2_valid_q && !ready_i);
  end

  always_ff @(posedge clk_i) begin
    s1_x_q  <= s1_x_d;
    s1_y_q  <= s1_y_d;
    s1_f_q  <= s1_f_d;
    s1_no_q <= s1_no_d;
  end

  // Result registers are reset so the outputs show a clean idle value
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      s2_out_q   <= '0;
      s2_zr_q    <= 1'b1;
      s2_ng_q    <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s2_valid_d;
      s2_out_q   <= s2_out_d;
      s2_zr_q    <= s2_zr_d;
      s2_ng_q    <= s2_ng_d;
    end
  end

  assign valid_o = s2_valid_q;
  assign out_o   = s2_out_q;
  assign zr_o    = s2_zr_q;
  assign ng_o    = s2_ng_q;

`ifdef ALU_OVF_EN
  logic s2_ov_q, s2_ov_d;
  logic ovf;

  // Overflow is judged on the sum before the output inversion
  always_comb begin
    ovf     = s1_f_q && (s1_x_q[MSB] == s1_y_q[MSB]) && (r[MSB] != s1_x_q[MSB]);
    s2_ov_d = s1_adv ? ovf : s2_ov_q;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      s2_ov_q <= 1'b0;
    end else begin
      s2_ov_q <= s2_ov_d;
    end
  end

  assign ov_o = s2_ov_q;
`else
  assign ov_o = 1'b0;
`endif

endmodule

// File: tb/tb_hack_alu_pipe.sv
// Self-checking bench for hack_alu_pipe (WIDTH=16) using a transaction-level reference model.
// Overflow expectations follow ALU_OVF_EN when the bench is built with it.
module tb_hack_alu_pipe;

  localparam int WIDTH = 16;

  logic             clk_i = 1'b0;
  logic             rst_ni;
  logic             valid_i;
  logic             ready_o;
  logic [WIDTH-1:0] x_i;
  logic [WIDTH-1:0] y_i;
  logic             zx_i, nx_i, zy_i, ny_i, f_i, no_i;
  logic             valid_o;
  logic             ready_i;
  logic [WIDTH-1:0] out_o;
  logic             zr_o, ng_o, ov_o;

  hack_alu_pipe #(.WIDTH(WIDTH)) dut (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .valid_i (valid_i),
    .ready_o (ready_o),
    .x_i     (x_i),
    .y_i     (y_i),
    .zx_i    (zx_i),
    .nx_i    (nx_i),
    .zy_i    (zy_i),
    .ny_i    (ny_i),
    .f_i     (f_i),
    .no_i    (no_i),
    .valid_o (valid_o),
    .ready_i (ready_i),
    .out_o   (out_o),
    .zr_o    (zr_o),
    .ng_o    (ng_o),
    .ov_o    (ov_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [15:0] x;
    logic [15:0] y;
    logic        zx;
    logic        nx;
    logic        zy;
    logic        ny;
    logic        f;
    logic        no;
  } beat_t;

  // Accepted beats in order; the head is the one showing on the output once head_s2 is set
  beat_t q[$];
  logic  head_s2 = 1'b0;
  int    pass_cnt = 0;
  int    total_cnt = 0;
  bit    checks_on = 1'b0;

`ifdef ALU_OVF_EN
  localparam logic OVF_ON = 1'b1;
`else
  localparam logic OVF_ON = 1'b0;
`endif

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) begin
      pass_cnt++;
    end else begin
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic beat_t mk(input logic [15:0] x, input logic [15:0] y, input logic zx,
                               input logic nx, input logic zy, input logic ny,
                               input logic f, input logic no);
    beat_t b;
    b.x = x; b.y = y; b.zx = zx; b.nx = nx; b.zy = zy; b.ny = ny; b.f = f; b.no = no;
    return b;
  endfunction

  // Returns {ov, ng, zr, out} straight from the ALU rules
  function automatic logic [18:0] model_result(input beat_t b);
    logic [15:0] xp, yp, r, o;
    int          s;
    logic        ov;
    xp = b.zx ? 16'h0000 : b.x;
    if (b.nx) xp = ~xp;
    yp = b.zy ? 16'h0000 : b.y;
    if (b.ny) yp = ~yp;
    if (b.f) r = 16'((32'(xp) + 32'(yp)) % 32'h10000);
    else     r = xp & yp;
    o  = b.no ? ~r : r;
    s  = int'($signed(xp)) + int'($signed(yp));
    ov = OVF_ON && b.f && ((s > 32767) || (s < -32768));
    return {ov, o[15], (o == 16'h0000), o};
  endfunction

  task automatic checkOutput();
    logic        exp_valid, exp_ready;
    logic [18:0] e;
    exp_valid = head_s2;
    exp_ready = (q.size() < 2) || ready_i;
    check("valid_o", 32'(valid_o), 32'(exp_valid));
    check("ready_o", 32'(ready_o), 32'(exp_ready));
    if (exp_valid) begin
      e = model_result(q[0]);
      check("out_o", 32'(out_o), 32'(e[15:0]));
      check("zr_o", 32'(zr_o), 32'(e[16]));
      check("ng_o", 32'(ng_o), 32'(e[17]));
      check("ov_o", 32'(ov_o), 32'(e[18]));
    end
  endtask

  // One clock: drive at negedge, check mid-cycle, then advance the model at the rising edge
  task automatic applyStimulus(input logic rst_n, input logic vld, input beat_t b,
                               input logic rdy, output logic acc);
    logic s2_free;
    @(negedge clk_i);
    rst_ni  = rst_n;
    valid_i = vld;
    x_i = b.x; y_i = b.y;
    zx_i = b.zx; nx_i = b.nx; zy_i = b.zy; ny_i = b.ny; f_i = b.f; no_i = b.no;
    ready_i = rdy;
    #1;
    if (checks_on) checkOutput();
    acc = rst_n && vld && ((q.size() < 2) || rdy);
    s2_free = !head_s2 || rdy;
    @(posedge clk_i);
    if (!rst_n) begin
      q.delete();
      head_s2 = 1'b0;
    end else begin
      if (head_s2 && rdy) begin
        void'(q.pop_front());
        head_s2 = 1'b0;
      end
      if (q.size() > 0 && !head_s2 && s2_free) head_s2 = 1'b1;
      if (acc) q.push_back(b);
    end
  endtask

  initial begin
    beat_t idle;
    logic  acc;
    idle = mk(16'h0, 16'h0, 0, 0, 0, 0, 0, 0);
    rst_ni = 1'b0; valid_i = 1'b0; ready_i = 1'b1;
    x_i = '0; y_i = '0; zx_i = 0; nx_i = 0; zy_i = 0; ny_i = 0; f_i = 0; no_i = 0;

    // Reset for 5 cycles then release
    for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b0, idle, 1'b1, acc);
    @(negedge clk_i);
    rst_ni = 1'b1;
    #1;
    check("rst_valid_o", 32'(valid_o), 32'd0);
    check("rst_out_o", 32'(out_o), 32'h0000);
    check("rst_zr_o", 32'(zr_o), 32'd1);
    check("rst_ng_o", 32'(ng_o), 32'd0);
    check("rst_ov_o", 32'(ov_o), 32'd0);
    check("rst_ready_o", 32'(ready_o), 32'd1);
    checks_on = 1'b1;

    // x - y via nx/no, with latency check
    applyStimulus(1'b1, 1'b1, mk(16'd1, 16'd5, 0, 1, 0, 0, 1, 1), 1'b1, acc);
    #2 check("t2_not_yet_valid", 32'(valid_o), 32'd0);
    applyStimulus(1'b1, 1'b0, idle, 1'b1, acc);
    #2;
    check("t2_valid", 32'(valid_o), 32'd1);
    check("t2_out", 32'(out_o), 32'hFFFC);
    check("t2_zr", 32'(zr_o), 32'd0);
    check("t2_ng", 32'(ng_o), 32'd1);
    applyStimulus(1'b1, 1'b0, idle, 1'b1, acc);

    // Back-to-back beats at full throughput
    applyStimulus(1'b1, 1'b1, mk(16'd3, 16'd4, 0, 0, 0, 0, 1, 0), 1'b1, acc);
    applyStimulus(1'b1, 1'b1, mk(16'h00F0, 16'h0FF0, 0, 0, 0, 0, 0, 0), 1'b1, acc);
    #2 check("t3_out0", 32'(out_o), 32'h0007);
    applyStimulus(1'b1, 1'b1, mk(16'h1234, 16'h5678, 1, 0, 1, 0, 1, 0), 1'b1, acc);
    #2 check("t3_out1", 32'(out_o), 32'h00F0);
    applyStimulus(1'b1, 1'b0, idle, 1'b1, acc);
    #2;
    check("t3_out2", 32'(out_o), 32'h0000);
    check("t3_zr2", 32'(zr_o), 32'd1);
    check("t3_valid2", 32'(valid_o), 32'd1);
    applyStimulus(1'b1, 1'b0, idle, 1'b1, acc);

    // Backpressure: two beats buffer, third waits
    applyStimulus(1'b1, 1'b1, mk(16'd10, 16'd20, 0, 0, 0, 0, 1, 0), 1'b0, acc);
    applyStimulus(1'b1, 1'b1, mk(16'hFFFF, 16'd1, 0, 0, 0, 0, 1, 0), 1'b0, acc);
    for (int i = 0; i < 3; i++)
      applyStimulus(1'b1, 1'b1, mk(16'h1234, 16'h00FF, 0, 0, 0, 0, 0, 0), 1'b0, acc);
    #2 check("t4_ready_low", 32'(ready_o), 32'd0);
    applyStimulus(1'b1, 1'b1, mk(16'h1234, 16'h00FF, 0, 0, 0, 0, 0, 0), 1'b1, acc);
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b0, idle, 1'b1, acc);

    // Reset with two beats in flight
    applyStimulus(1'b1, 1'b1, mk(16'd7, 16'd9, 0, 0, 0, 0, 1, 0), 1'b0, acc);
    applyStimulus(1'b1, 1'b1, mk(16'd1, 16'd1, 0, 0, 0, 0, 1, 1), 1'b0, acc);
    applyStimulus(1'b0, 1'b0, idle, 1'b0, acc);
    #2;
    check("t5_valid_after_rst", 32'(valid_o), 32'd0);
    check("t5_out_after_rst", 32'(out_o), 32'h0000);
    check("t5_zr_after_rst", 32'(zr_o), 32'd1);
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b0, idle, 1'b1, acc);

    // Signed overflow boundary
    applyStimulus(1'b1, 1'b1, mk(16'h7FFF, 16'h0001, 0, 0, 0, 0, 1, 0), 1'b1, acc);
    applyStimulus(1'b1, 1'b1, mk(16'd2, 16'd3, 0, 0, 0, 0, 1, 0), 1'b1, acc);
    #2;
    check("t6_out", 32'(out_o), 32'h8000);
    check("t6_ng", 32'(ng_o), 32'd1);
    check("t6_ov", 32'(ov_o), 32'(OVF_ON));
    applyStimulus(1'b1, 1'b0, idle, 1'b1, acc);
    #2;
    check("t6_out_small", 32'(out_o), 32'h0005);
    check("t6_ov_small", 32'(ov_o), 32'd0);
    applyStimulus(1'b1, 1'b0, idle, 1'b1, acc);

    // Randomised traffic with random backpressure and rare resets
    for (int i = 0; i < 600; i++) begin
      beat_t rb;
      rb = mk(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
              1'($urandom), 1'($urandom), 1'($urandom));
      applyStimulus(1'($urandom_range(0, 99) != 0), 1'($urandom_range(0, 9) < 7), rb,
                    1'($urandom_range(0, 9) < 6), acc);
    end
    for (int i = 0; i < 6; i++) applyStimulus(1'b1, 1'b0, idle, 1'b1, acc);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
